// File: rtl/dca_matrix_lsu_scratch_pkg.sv
// Shared definitions for the matrix LSU scratch responder: instruction
// layout, opcodes, FSM state encoding and row-width helpers.
package dca_matrix_lsu_scratch_pkg;

    // Instruction word width
    localparam int BW_DCA_MATRIX_LSU_INST = 32;

    // Instruction field positions
    localparam int OP_LSB   = 0;
    localparam int OP_W     = 2;
    localparam int BASE_LSB = 2;
    localparam int BASE_W   = 8;
    localparam int CNT_LSB  = 10;
    localparam int CNT_W    = 8;

    // Opcodes; every other encoding is a nop
    localparam logic [1:0] OPCODE_LOAD  = 2'b01;
    localparam logic [1:0] OPCODE_STORE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STORE  = 3'd3,
        ST_FINISH = 3'd4
    } lsu_state_t;

    // Number of columns per tensor row for a matrix size selector
    function automatic int matrix_num_col(input int size_para);
        return (size_para > 0) ? size_para : 1;
    endfunction

    // Scalar width in bits for a tensor format selector
    function automatic int tensor_scalar_bw(input int tensor_para);
        case (tensor_para)
            1:       return 16;
            2:       return 32;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/dca_matrix_lsu_scratch_if.sv
// Instruction and row-stream bus between the MAC core (master) and the LSU
// responder (slave).
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; the valid side holds its data stable
// until that edge and never waits on ready before raising valid.
interface dca_matrix_lsu_scratch_if #(
    parameter int BW_ROW  = 64,
    parameter int BW_INST = 32
);
    logic               sinst_wvalid;
    logic [BW_INST-1:0] sinst_wdata;
    logic               sinst_wready;
    logic               sinst_decode_finish;
    logic               sinst_execute_finish;
    logic               sinst_busy;

    logic               sload_tensor_row_wvalid;
    logic               sload_tensor_row_wlast;
    logic [BW_ROW-1:0]  sload_tensor_row_wdata;
    logic               sload_tensor_row_wready;

    logic               sstore_tensor_row_rvalid;
    logic               sstore_tensor_row_rlast;
    logic               sstore_tensor_row_rready;
    logic [BW_ROW-1:0]  sstore_tensor_row_rdata;

    modport slave (
        input  sinst_wvalid, sinst_wdata,
        output sinst_wready, sinst_decode_finish, sinst_execute_finish, sinst_busy,
        output sload_tensor_row_wvalid, sload_tensor_row_wlast, sload_tensor_row_wdata,
        input  sload_tensor_row_wready,
        output sstore_tensor_row_rvalid, sstore_tensor_row_rlast,
        input  sstore_tensor_row_rready, sstore_tensor_row_rdata
    );

    modport master (
        output sinst_wvalid, sinst_wdata,
        input  sinst_wready, sinst_decode_finish, sinst_execute_finish, sinst_busy,
        input  sload_tensor_row_wvalid, sload_tensor_row_wlast, sload_tensor_row_wdata,
        output sload_tensor_row_wready,
        input  sstore_tensor_row_rvalid, sstore_tensor_row_rlast,
        output sstore_tensor_row_rready, sstore_tensor_row_rdata
    );

endinterface

// File: rtl/dca_matrix_lsu_scratch_row_mem.sv
// Scratch row memory: one synchronous write port and one read port whose
// output register holds its value until the next read enable.
module dca_matrix_row_mem #(
    parameter int NUM_ROW_ENTRY = 64,
    parameter int BW_ROW        = 64,
    parameter int AW            = 6
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BW_ROW-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [BW_ROW-1:0] rd_data
);

    logic [BW_ROW-1:0] mem [NUM_ROW_ENTRY];

    // Array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read; the held value doubles as the stalled load row
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dca_matrix_lsu_scratch.sv
// Matrix LSU responder: accepts one instruction at a time and streams rows
// between the scratch row memory and the MAC core.
module dca_matrix_lsu_scratch
    import dca_matrix_lsu_scratch_pkg::*;
#(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int TENSOR_PARA      = 0,
    parameter int NUM_ROW_ENTRY    = 64
) (
    input  logic                     clk,
    input  logic                     rstnn,
    dca_matrix_lsu_scratch_if.slave  bus,
    output lsu_state_t               dbg_state
);

    localparam int BW_ROW = tensor_scalar_bw(TENSOR_PARA) * matrix_num_col(MATRIX_SIZE_PARA);
    localparam int AW     = (NUM_ROW_ENTRY > 1) ? $clog2(NUM_ROW_ENTRY) : 1;

    lsu_state_t        state, state_nxt;
    logic [AW-1:0]     addr;
    logic [AW-1:0]     addr_inc;
    logic [CNT_W-1:0]  rem_m1;
    logic [1:0]        opcode;
    logic              advance;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              wr_en;

    assign addr_inc  = addr + AW'(1);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, handshake outputs and memory port controls
    always_comb begin
        state_nxt                    = state;
        bus.sinst_wready             = 1'b0;
        bus.sinst_decode_finish      = 1'b0;
        bus.sinst_execute_finish     = 1'b0;
        bus.sinst_busy               = 1'b0;
        bus.sload_tensor_row_wvalid  = 1'b0;
        bus.sload_tensor_row_wlast   = 1'b0;
        bus.sstore_tensor_row_rvalid = 1'b0;
        bus.sstore_tensor_row_rlast  = 1'b0;
        advance                      = 1'b0;
        rd_en                        = 1'b0;
        rd_addr                      = addr;
        wr_en                        = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.sinst_wready = 1'b1;
                if (bus.sinst_wvalid) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                bus.sinst_decode_finish = 1'b1;
                bus.sinst_busy          = 1'b1;
                if (opcode == OPCODE_LOAD) begin
                    rd_en     = 1'b1;
                    state_nxt = ST_LOAD;
                end else if (opcode == OPCODE_STORE) begin
                    state_nxt = ST_STORE;
                end else begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_LOAD: begin
                bus.sinst_busy              = 1'b1;
                bus.sload_tensor_row_wvalid = 1'b1;
                bus.sload_tensor_row_wlast  = (rem_m1 == '0);
                if (bus.sload_tensor_row_wready) begin
                    advance = 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = addr_inc;
                    if (rem_m1 == '0) state_nxt = ST_FINISH;
                end
            end
            ST_STORE: begin
                bus.sinst_busy               = 1'b1;
                bus.sstore_tensor_row_rvalid = 1'b1;
                bus.sstore_tensor_row_rlast  = (rem_m1 == '0);
                if (bus.sstore_tensor_row_rready) begin
                    advance = 1'b1;
                    wr_en   = 1'b1;
                    if (rem_m1 == '0) state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                bus.sinst_execute_finish = 1'b1;
                bus.sinst_busy           = 1'b1;
                state_nxt                = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Instruction fields latch on accept; address and count step per row
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            addr   <= '0;
            rem_m1 <= '0;
            opcode <= '0;
        end else if (state == ST_IDLE && bus.sinst_wvalid) begin
            addr   <= bus.sinst_wdata[BASE_LSB +: AW];
            rem_m1 <= bus.sinst_wdata[CNT_LSB +: CNT_W];
            opcode <= bus.sinst_wdata[OP_LSB +: OP_W];
        end else if (advance) begin
            addr   <= addr_inc;
            rem_m1 <= rem_m1 - CNT_W'(1);
        end
    end

    dca_matrix_row_mem #(
        .NUM_ROW_ENTRY (NUM_ROW_ENTRY),
        .BW_ROW        (BW_ROW),
        .AW            (AW)
    ) u_row_mem (
        .clk     (clk),
        .rstnn   (rstnn),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_data (bus.sstore_tensor_row_rdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (bus.sload_tensor_row_wdata)
    );

endmodule
